shuffle_ram_ctrl: RTL and testbench

Controller that sits directly upstream of `shuffle_ram` in the ASE out-of-order response path. It accepts transactions over a valid/ready stream and writes each one into a free slot of the RAM. It then reads the slots back in a pseudo-random order chosen by an LFSR and presents them on a valid/ready output stream. The purpose is to exercise AFU tolerance of reordered responses.

---
 rtl/shuffle_ram_ctrl.sv | 179 +++++++++++++++++
 tb/tb_shuffle_ram_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shuffle_ram_ctrl.sv
// shuffle_ram_ctrl
//
// Sits in front of a simple dual-port RAM (shuffle_ram). Incoming payloads
// are written into the lowest free slot. Occupied slots are read back in a
// pseudo-random order picked by an 8-bit LFSR. Read data lands in a 2-entry
// output FIFO that drives the output stream.
//
// Handshake: a transfer happens on a rising edge where valid && ready. Valid
// never depends on ready. Data is held stable while valid is high and ready
// is low.
//
// Ports
//   clk, rst               clock and synchronous active-high reset
//   in_valid/in_data       input stream; in_ready is high while a slot is free
//   out_valid/out_data     output stream; out_ready is the consumer acceptance
//   ram_we/ram_waddr/ram_din   RAM write port (combinational)
//   ram_raddr/ram_dout     RAM read port; dout is valid one cycle after raddr
//   occupancy              number of occupied RAM slots
module shuffle_ram_ctrl #(
  parameter int          BUS_SIZE_ADDR = 4,
  parameter int          BUS_SIZE_DATA = 32,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [BUS_SIZE_DATA-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [BUS_SIZE_DATA-1:0] out_data,
  input  logic                     out_ready,
  output logic                     ram_we,
  output logic [BUS_SIZE_ADDR-1:0] ram_waddr,
  output logic [BUS_SIZE_DATA-1:0] ram_din,
  output logic [BUS_SIZE_ADDR-1:0] ram_raddr,
  input  logic [BUS_SIZE_DATA-1:0] ram_dout,
  output logic [BUS_SIZE_ADDR:0]   occupancy
);

  localparam int AW    = BUS_SIZE_ADDR;
  localparam int DW    = BUS_SIZE_DATA;
  localparam int DEPTH = 1 << AW;

  // State
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [AW-1:0]    raddr_q;
  logic             infl_q, infl_d;     // read issued last cycle, dout arriving now
  logic [1:0]       cnt_q, cnt_d;       // FIFO entries (0..2)
  logic [DW-1:0]    mem0_q, mem0_d;     // FIFO head
  logic [DW-1:0]    mem1_q, mem1_d;

  // Lowest-index free slot
  logic [AW-1:0] free_idx;
  logic          free_found;
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!free_found && !busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = AW'(i);
      end
    end
  end

  assign in_ready  = ~(&busy_q);
  assign ram_we    = in_valid && in_ready;
  assign ram_waddr = free_idx;
  assign ram_din   = in_data;

  // Read candidate: first busy slot at or after the LFSR start index.
  // The AW-bit add wraps DEPTH-1 back to 0 naturally.
  logic [AW-1:0] start_idx;
  logic [AW-1:0] scan_idx;
  logic [AW-1:0] cand_idx;
  logic          cand_found;
  assign start_idx = lfsr_q[AW-1:0];
  always_comb begin
    scan_idx   = '0;
    cand_idx   = '0;
    cand_found = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = start_idx + AW'(k);
      if (!cand_found && busy_q[scan_idx]) begin
        cand_found = 1'b1;
        cand_idx   = scan_idx;
      end
    end
  end

  // Credit: FIFO entries plus the read in flight may never exceed two,
  // except that a pop this cycle frees one place for the next push.
  logic       pop;
  logic       push;
  logic [2:0] credit_used;
  logic       credit_ok;
  logic       issue;

  assign out_valid   = (cnt_q != 2'd0);
  assign out_data    = mem0_q;
  assign pop         = out_valid && out_ready;
  assign push        = infl_q;
  assign credit_used = {1'b0, cnt_q} + {2'b00, infl_q};
  assign credit_ok   = (credit_used < 3'd2) || ((credit_used == 3'd2) && pop);
  assign issue       = cand_found && credit_ok;

  // Hold the last issued address when idle so the read port stays quiet.
  assign ram_raddr = issue ? cand_idx : raddr_q;

  // Bitmap update: write and read never touch the same slot (one is free,
  // the other busy), so both edits can be applied independently.
  always_comb begin
    busy_d = busy_q;
    if (ram_we) busy_d[free_idx] = 1'b1;
    if (issue)  busy_d[cand_idx] = 1'b0;
  end

  // Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign infl_d = issue;

  // Output FIFO as a two-register shift queue with the head in mem0.
  // The credit rule guarantees a push never meets a full FIFO without a pop.
  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) mem0_d = ram_dout;
        else               mem1_d = ram_dout;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        mem0_d = mem1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          mem0_d = ram_dout;
        end else begin
          mem0_d = mem1_q;
          mem1_d = ram_dout;
        end
      end
      default: ;
    endcase
  end

  // Occupancy
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + (AW+1)'(busy_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      lfsr_q  <= LFSR_SEED;
      raddr_q <= '0;
      infl_q  <= 1'b0;
      cnt_q   <= 2'd0;
      mem0_q  <= '0;
      mem1_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      lfsr_q  <= lfsr_d;
      raddr_q <= ram_raddr;
      infl_q  <= infl_d;
      cnt_q   <= cnt_d;
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
    end
  end

endmodule

// File: tb/tb_shuffle_ram_ctrl.sv
// Testbench for shuffle_ram_ctrl. Includes a behavioural synchronous RAM,
// an acceptance logger that fills the expected queue and a monitor that
// removes every delivered payload from it (order is free, multiplicity is not).
module tb_shuffle_ram_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int NCYC  = 12000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_din;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_dout = '0;
  logic [AW:0]   occupancy;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] in_log[$];
  logic [DW-1:0] out_log[$];
  logic [DW-1:0] order1[$];
  bit            v_pat[NCYC];
  bit            r_pat[NCYC];

  shuffle_ram_ctrl #(.BUS_SIZE_ADDR(AW), .BUS_SIZE_DATA(DW), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din),
    .ram_raddr(ram_raddr), .ram_dout(ram_dout), .occupancy(occupancy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Behavioural shuffle_ram: registered read, write on we
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_waddr] <= ram_din;
    ram_dout <= ram_mem[ram_raddr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Acceptance logger: every accepted input is an expected output
  always @(negedge clk) begin
    if (!rst) begin
      check("ram_we_vs_handshake", 64'(ram_we), 64'(in_valid && in_ready));
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        in_log.push_back(in_data);
        check("ram_din", 64'(ram_din), 64'(in_data));
      end
      check("occupancy_bound", 64'(occupancy <= (AW+1)'(DEPTH)), 64'd1);
    end
  end

  // Monitor: each delivered word must be pending exactly once
  always @(negedge clk) begin
    int idx;
    if (!rst && out_valid && out_ready) begin
      idx = -1;
      foreach (exp_q[i]) if (idx < 0 && exp_q[i] == out_data) idx = i;
      checks++;
      if (idx < 0) begin
        failures++;
        $display("FAIL out_unexpected actual=%0h expected=pending_word", out_data);
      end else begin
        exp_q.delete(idx);
      end
      out_log.push_back(out_data);
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    exp_q.delete();
    in_log.delete();
    out_log.delete();
  endtask

  task automatic drain(input string name);
    int c;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (c = 0; c < 300; c++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_stream();
    int n;
    n = 0;
    do_reset();
    for (int c = 0; c < NCYC && n < 2000; c++) begin
      in_valid  = v_pat[c];
      in_data   = 32'h1000_0000 + 32'(n);
      out_ready = r_pat[c];
      @(negedge clk);
      if (in_valid && in_ready) n++;
      tick();
    end
    check("stream_accepted", 64'(n), 64'd2000);
    drain("stream");
    check("stream_out_count", 64'(out_log.size()), 64'd2000);
  endtask

  initial begin
    int n;
    int same;
    int mism;
    logic [DW-1:0] d0;
    logic [AW-1:0] r0;

    // 1. Reset state
    do_reset();
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_ram_we",    64'(ram_we),    64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_ram_raddr", 64'(ram_raddr), 64'd0);
    check("rst_ram_waddr", 64'(ram_waddr), 64'd0);

    // 2. Fill with the consumer stalled: 16 + 2 words fit (RAM plus FIFO)
    tick();
    n = 0;
    in_valid = 1'b1;
    in_data  = 32'h100;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (n == 16) begin
        check("fill_occ_after16",   64'(occupancy), 64'd14);
        check("fill_outv_after16",  64'(out_valid), 64'd1);
      end
      if (!in_ready) break;
      if (n < 2) check("fill_waddr_first", 64'(ram_waddr), 64'(n));
      tick();
      n++;
      in_data = 32'h100 + 32'(n);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("fill_total",     64'(n),         64'(DEPTH + 2));
    check("fill_occ_full",  64'(occupancy), 64'(DEPTH));
    check("fill_in_ready",  64'(in_ready),  64'd0);
    check("fill_out_valid", 64'(out_valid), 64'd1);

    // 3. Drain
    tick();
    drain("drain");
    @(negedge clk);
    check("drain_out_valid", 64'(out_valid), 64'd0);
    check("drain_occ",       64'(occupancy), 64'd0);
    check("drain_count",     64'(out_log.size()), 64'(DEPTH + 2));
    same = (out_log.size() == in_log.size()) ? 1 : 0;
    foreach (out_log[i]) if (i < in_log.size() && out_log[i] != in_log[i]) same = 0;
    check("drain_reordered", 64'(same), 64'd0);

    // 4. Backpressure with two words buffered
    do_reset();
    in_valid = 1'b1; in_data = 32'h200; tick();
    in_data  = 32'h201; tick();
    in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_head",      64'(out_data),  64'h200);
    d0 = out_data;
    r0 = ram_raddr;
    for (int c = 0; c < 10; c++) begin
      tick();
      @(negedge clk);
      check("bp_data_stable",  64'(out_data),  64'(d0));
      check("bp_raddr_stable", 64'(ram_raddr), 64'(r0));
    end
    tick();
    drain("bp");
    check("bp_count", 64'(out_log.size()), 64'd2);

    // 5. Random streaming, twice with the same stimulus
    foreach (v_pat[i]) begin
      v_pat[i] = 1'($urandom_range(0, 1));
      r_pat[i] = 1'($urandom_range(0, 1));
    end
    run_stream();
    order1 = out_log;
    run_stream();
    check("repeat_size", 64'(out_log.size()), 64'(order1.size()));
    mism = 0;
    foreach (out_log[i]) if (i < order1.size() && out_log[i] != order1[i]) mism++;
    check("repeat_order", 64'(mism), 64'd0);

    // 6. Mid-operation reset, then a fresh word at minimum latency
    do_reset();
    in_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      in_data = 32'h300 + 32'(n);
      @(negedge clk);
      if (occupancy == 5'd8) break;
      tick();
      n++;
    end
    check("mid_reached8", 64'(occupancy), 64'd8);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_occ",       64'(occupancy), 64'd0);
    check("mid_out_valid", 64'(out_valid), 64'd0);
    tick();
    in_valid  = 1'b1;
    in_data   = 32'hDEAD;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_c1_out_valid", 64'(out_valid), 64'd0);
    tick();
    @(negedge clk);
    check("lat_c2_out_valid", 64'(out_valid), 64'd0);
    tick();
    @(negedge clk);
    check("lat_c3_out_valid", 64'(out_valid), 64'd1);
    check("lat_c3_out_data",  64'(out_data),  64'hDEAD);
    tick();
    repeat (5) tick();
    @(negedge clk);
    check("mid_no_stale", 64'(out_valid), 64'd0);
    check("mid_pending",  64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
